// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - LEGv8 condition codes, redirect FSM encoding and condition evaluator
package branch_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_LO = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_FLAGS = 2'd1;
  localparam logic [1:0] S_WAIT_FETCH = 2'd2;
  localparam logic [1:0] S_DRAIN      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = S_IDLE,
    ST_WAIT_FLAGS = S_WAIT_FLAGS,
    ST_WAIT_FETCH = S_WAIT_FETCH,
    ST_DRAIN      = S_DRAIN
  } state_t;

  // NV is deliberately treated as always-true, matching AL.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    {n, z, c, v} = nzcv;
    ok = 1'b1;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = !z;
      COND_HS: ok = c;
      COND_LO: ok = !c;
      COND_MI: ok = n;
      COND_PL: ok = !n;
      COND_VS: ok = v;
      COND_VC: ok = !v;
      COND_HI: ok = c && !z;
      COND_LS: ok = !(c && !z);
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = !z && (n == v);
      COND_LE: ok = !(!z && (n == v));
      COND_AL: ok = 1'b1;
      COND_NV: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational B.cond evaluator: cond field + NZCV -> cond_ok
module branch_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ok
);
  import branch_ctrl_pkg::*;

  assign cond_ok = cond_eval(cond, nzcv);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - EX-stage branch resolution, PC redirect, squash/drain sequencing
// and perf counters for the 5-stage LEGv8 pipeline (static not-taken prediction).
module branch_redirect_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_uncond_br,
  input  logic              ex_cbz,
  input  logic              ex_bcond,
  input  logic [3:0]        ex_cond,
  input  logic              ex_alu_zero,
  input  logic [3:0]        flags_nzcv,
  input  logic              flags_valid,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              fetch_ready,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              stall_front,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  stall_count
);
  import branch_ctrl_pkg::*;

  localparam logic [2:0] DRAIN_LOAD = 3'(FLUSH_DEPTH);

  state_t            state_q, state_d;
  logic [2:0]        drain_q, drain_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]  taken_q, stall_q;
  logic              cond_ok, taken;
  logic              load_c, stall_c;
  logic [ADDR_W-1:0] addr_c;

  branch_cond_eval u_cond_eval (
    .cond    (ex_cond),
    .nzcv    (flags_nzcv),
    .cond_ok (cond_ok)
  );

  assign taken = ex_uncond_br | (ex_cbz & ex_alu_zero) | (ex_bcond & cond_ok);

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    target_d = target_q;
    load_c   = 1'b0;
    stall_c  = 1'b0;
    addr_c   = '0;
    case (state_q)
      // WAIT_FLAGS re-runs the IDLE decision once the flags arrive; EX is frozen meanwhile.
      ST_IDLE, ST_WAIT_FLAGS: begin
        if (!ex_valid) begin
          state_d = ST_IDLE;
        end else if (ex_bcond && !flags_valid) begin
          stall_c = 1'b1;
          state_d = ST_WAIT_FLAGS;
        end else if (taken && fetch_ready) begin
          load_c  = 1'b1;
          addr_c  = ex_target;
          drain_d = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end else if (taken) begin
          stall_c  = 1'b1;
          target_d = ex_target;
          state_d  = ST_WAIT_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_FETCH: begin
        if (fetch_ready) begin
          load_c  = 1'b1;
          addr_c  = target_q;
          drain_d = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end else begin
          stall_c = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q <= 3'd1) begin
          drain_d = '0;
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Mealy outputs are forced low while reset is held, independent of the clock.
  assign pc_load      = reset_n & load_c;
  assign flush_if_id  = pc_load;
  assign flush_id_ex  = pc_load;
  assign stall_front  = reset_n & stall_c;
  assign pc_load_addr = pc_load ? addr_c : '0;
  assign taken_count  = taken_q;
  assign stall_count  = stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      drain_q  <= '0;
      target_q <= '0;
      taken_q  <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      target_q <= target_d;
      if (pc_load && (taken_q != {CNT_W{1'b1}}))
        taken_q <= taken_q + CNT_W'(1);
      if (stall_front && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench: directed vector table, multi-cycle
// redirect/stall sequences, cond evaluator sweep and counter saturation.
module tb_branch_redirect_ctrl;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ex_valid, ex_uncond_br, ex_cbz, ex_bcond, ex_alu_zero, flags_valid, fetch_ready;
  logic [3:0]        ex_cond, flags_nzcv;
  logic [ADDR_W-1:0] ex_target;
  logic              pc_load, flush_if_id, flush_id_ex, stall_front;
  logic [ADDR_W-1:0] pc_load_addr;
  logic [CNT_W-1:0]  taken_count, stall_count;

  logic              s_pc_load, s_flush_if_id, s_flush_id_ex, s_stall_front;
  logic [ADDR_W-1:0] s_pc_load_addr;
  logic [3:0]        s_taken_count, s_stall_count;

  logic [3:0]        ce_cond, ce_nzcv;
  logic              ce_ok;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_uncond_br(ex_uncond_br),
    .ex_cbz(ex_cbz), .ex_bcond(ex_bcond), .ex_cond(ex_cond), .ex_alu_zero(ex_alu_zero),
    .flags_nzcv(flags_nzcv), .flags_valid(flags_valid), .ex_target(ex_target),
    .fetch_ready(fetch_ready), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall_front(stall_front),
    .taken_count(taken_count), .stall_count(stall_count)
  );

  branch_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_DEPTH(1), .CNT_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_uncond_br(ex_uncond_br),
    .ex_cbz(ex_cbz), .ex_bcond(ex_bcond), .ex_cond(ex_cond), .ex_alu_zero(ex_alu_zero),
    .flags_nzcv(flags_nzcv), .flags_valid(flags_valid), .ex_target(ex_target),
    .fetch_ready(fetch_ready), .pc_load(s_pc_load), .pc_load_addr(s_pc_load_addr),
    .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .stall_front(s_stall_front),
    .taken_count(s_taken_count), .stall_count(s_stall_count)
  );

  branch_cond_eval u_ce (.cond(ce_cond), .nzcv(ce_nzcv), .cond_ok(ce_ok));

  typedef struct {
    logic              v, unc, cbz, bc;
    logic [3:0]        cond;
    logic              zero;
    logic [3:0]        nzcv;
    logic              fv;
    logic [ADDR_W-1:0] tgt;
    logic              fr;
    logic [3:0]        exp_ctl;   // {pc_load, flush_if_id, flush_id_ex, stall_front}
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic v, unc, cbz, bc, input logic [3:0] cond, input logic zero,
                         input logic [3:0] nzcv, input logic fv, input logic [ADDR_W-1:0] tgt,
                         input logic fr, input logic [3:0] ctl, input logic [ADDR_W-1:0] addr);
    vec_t e;
    e.v = v; e.unc = unc; e.cbz = cbz; e.bc = bc; e.cond = cond; e.zero = zero;
    e.nzcv = nzcv; e.fv = fv; e.tgt = tgt; e.fr = fr; e.exp_ctl = ctl; e.exp_addr = addr;
    vq.push_back(e);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] outs();
    return {pc_load, flush_if_id, flush_id_ex, stall_front, pc_load_addr};
  endfunction

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy & !z;
      4'd9:  return !cy | z;
      4'd10: return n ~^ v;
      4'd11: return n ^ v;
      4'd12: return !z & (n ~^ v);
      4'd13: return z | (n ^ v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_inputs();
    ex_valid = 0; ex_uncond_br = 0; ex_cbz = 0; ex_bcond = 0; ex_cond = 0; ex_alu_zero = 0;
    flags_nzcv = 0; flags_valid = 1; ex_target = '0; fetch_ready = 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [67:0] NONE = 68'd0;

  initial begin
    logic [3:0] cnd, fl;
    clear_inputs();
    ce_cond = 0; ce_nzcv = 0;

    // Reset state: a taken B presented during reset must produce nothing.
    ex_valid = 1; ex_uncond_br = 1; ex_target = 64'h40;
    #12;
    check("reset_outs", outs(), NONE);
    check("reset_taken_cnt", taken_count, 0);
    check("reset_stall_cnt", stall_count, 0);

    // Single-cycle decisions from IDLE.
    add_vec(0,1,0,0, 4'd0, 0, 4'h0, 1, 64'h40, 1, 4'b0000, 64'h0);
    add_vec(1,1,0,0, 4'd0, 0, 4'h0, 1, 64'h40, 1, 4'b1110, 64'h40);
    add_vec(1,0,1,0, 4'd0, 0, 4'h0, 1, 64'h80, 1, 4'b0000, 64'h0);
    add_vec(1,0,1,0, 4'd0, 1, 4'h0, 1, 64'h80, 1, 4'b1110, 64'h80);
    add_vec(1,0,0,1, 4'd12,0, 4'h0, 0, 64'h90, 1, 4'b0001, 64'h0);
    add_vec(1,0,0,1, 4'd0, 0, 4'h4, 1, 64'hA0, 1, 4'b1110, 64'hA0);
    add_vec(1,0,0,1, 4'd0, 0, 4'h0, 1, 64'hA0, 1, 4'b0000, 64'h0);
    add_vec(1,1,0,0, 4'd0, 0, 4'h0, 1, 64'hB0, 0, 4'b0001, 64'h0);
    add_vec(1,0,1,1, 4'd1, 0, 4'h0, 1, 64'hC0, 1, 4'b1110, 64'hC0);
    add_vec(1,0,0,1, 4'd14,0, 4'hF, 1, 64'hD0, 1, 4'b1110, 64'hD0);
    add_vec(1,0,0,1, 4'd15,0, 4'h0, 1, 64'hE0, 1, 4'b1110, 64'hE0);
    add_vec(1,0,0,1, 4'd11,0, 4'h8, 1, 64'hF0, 1, 4'b1110, 64'hF0);
    add_vec(1,0,0,0, 4'd0, 1, 4'h0, 1, 64'h100,1, 4'b0000, 64'h0);
    add_vec(1,0,0,1, 4'd8, 0, 4'h6, 1, 64'h110,1, 4'b0000, 64'h0);
    add_vec(1,0,1,0, 4'd0, 1, 4'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 4'b1110, 64'hFFFF_FFFF_FFFF_FFFC);

    foreach (vq[i]) begin
      apply_reset();
      ex_valid = vq[i].v; ex_uncond_br = vq[i].unc; ex_cbz = vq[i].cbz; ex_bcond = vq[i].bc;
      ex_cond = vq[i].cond; ex_alu_zero = vq[i].zero; flags_nzcv = vq[i].nzcv;
      flags_valid = vq[i].fv; ex_target = vq[i].tgt; fetch_ready = vq[i].fr;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), {vq[i].exp_ctl, vq[i].exp_addr});
    end

    // B redirect, then exactly two masked EX cycles.
    apply_reset();
    ex_valid = 1; ex_uncond_br = 1; ex_target = 64'h40;
    @(negedge clk);
    check("b_redirect", outs(), {4'b1110, 64'h40});
    next_cycle(); @(negedge clk);
    check("b_mask1", outs(), NONE);
    check("b_taken_cnt", taken_count, 1);
    next_cycle(); @(negedge clk);
    check("b_mask2", outs(), NONE);
    next_cycle(); @(negedge clk);
    check("b_rearmed", outs(), {4'b1110, 64'h40});

    // B.GT waits 3 cycles for flags, then NZCV=0000 makes it taken.
    apply_reset();
    ex_valid = 1; ex_bcond = 1; ex_cond = 4'd12; flags_valid = 0; flags_nzcv = 4'h8; ex_target = 64'h500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bgt_stall%0d", i), outs(), {4'b0001, 64'h0});
      next_cycle();
    end
    flags_valid = 1; flags_nzcv = 4'h0;
    @(negedge clk);
    check("bgt_redirect", outs(), {4'b1110, 64'h500});
    next_cycle(); @(negedge clk);
    check("bgt_stall_cnt", stall_count, 3);
    check("bgt_taken_cnt", taken_count, 1);

    // B with fetch busy for 2 cycles; target changes mid-wait but the latched one wins.
    apply_reset();
    ex_valid = 1; ex_uncond_br = 1; ex_target = 64'h200; fetch_ready = 0;
    @(negedge clk);
    check("wf_stall0", outs(), {4'b0001, 64'h0});
    next_cycle();
    ex_target = 64'h300;
    @(negedge clk);
    check("wf_stall1", outs(), {4'b0001, 64'h0});
    next_cycle();
    fetch_ready = 1;
    @(negedge clk);
    check("wf_redirect", outs(), {4'b1110, 64'h200});
    next_cycle(); @(negedge clk);
    check("wf_drain", outs(), NONE);
    check("wf_stall_cnt", stall_count, 2);
    check("wf_taken_cnt", taken_count, 1);

    // Reset pulsed while in WAIT_FETCH drops the pending redirect.
    apply_reset();
    ex_valid = 1; ex_uncond_br = 1; ex_target = 64'h600; fetch_ready = 0;
    next_cycle(); @(negedge clk);
    check("rst_pre_stall", stall_front, 1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_outs_zero", outs(), NONE);
    check("rst_stall_cnt", stall_count, 0);
    ex_valid = 0; ex_uncond_br = 0; fetch_ready = 1;
    next_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_no_load%0d", i), outs(), NONE);
      next_cycle();
    end
    check("rst_taken_cnt", taken_count, 0);

    // Condition evaluator sweep, standalone.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        cnd = 4'(c); fl = 4'(f);
        ce_cond = cnd; ce_nzcv = fl;
        #1;
        check($sformatf("cond_c%0d_f%0h", c, f), ce_ok, ref_cond(cnd, fl));
        if (c >= 14) check($sformatf("al_nv_c%0d_f%0h", c, f), ce_ok, 1);
      end
    end

    // FLUSH_DEPTH=1 instance: one masked cycle, then taken_count saturates at 0xF.
    apply_reset();
    ex_valid = 1; ex_uncond_br = 1; ex_target = 64'h40;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4) check($sformatf("fd1_pattern%0d", i), s_pc_load, ((i % 2) == 0));
      next_cycle();
    end
    @(negedge clk);
    check("small_taken_sat", s_taken_count, 4'hF);
    fetch_ready = 0;
    for (int i = 0; i < 20; i++) next_cycle();
    @(negedge clk);
    check("small_stall_sat", s_stall_count, 4'hF);
    check("small_still_stall", s_stall_front, 1);
    check("small_taken_hold", s_taken_count, 4'hF);

    // Full-width stall_count saturation at 0xFFFF.
    apply_reset();
    ex_valid = 1; ex_uncond_br = 1; ex_target = 64'h700; fetch_ready = 0;
    for (int i = 0; i < 65540; i++) next_cycle();
    @(negedge clk);
    check("stall_sat", stall_count, 16'hFFFF);
    check("stall_sat_front", stall_front, 1);
    next_cycle();
    fetch_ready = 1;
    @(negedge clk);
    check("stall_sat_redirect", outs(), {4'b1110, 64'h700});
    next_cycle(); @(negedge clk);
    check("stall_sat_hold", stall_count, 16'hFFFF);
    check("stall_sat_taken", taken_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
